// File: rtl/risc16_mc_ctrl.sv
// risc16_mc_ctrl -- multi-cycle control sequencer for the RiSC-16 datapath.
//
// Each instruction is split into FETCH/DECODE/EXEC/MEM/WB steps so that one
// shared memory port serves both instruction fetch and data access.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   run             keep issuing instructions (sampled at boundaries / IDLE)
//   ir_opcode       IR[15:13], valid from DECODE onward
//   alu_zero        ALU result == 0
//   mem_ack         memory access complete (may coincide with mem_req)
//   mem_req/we/sel  memory request, write enable, address source (0 PC, 1 ALU)
//   ir_load         load IR from memory read data
//   pc_load/pc_src  PC load strobe and source (00 PC+1, 01 PC+imm, 10 regB)
//   reg_we/wb_src   register write enable and source (00 ALU, 01 mem, 10 PC)
//   alu_op          00 add, 01 nand, 10 pass imm<<6, 11 sub
//   alu_src_imm     ALU operand1: 0 regC, 1 immediate
//   state           current state encoding
//   retired         retired-instruction counter (wraps)
module risc16_mc_ctrl #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [2:0]       ir_opcode,
    input  logic             alu_zero,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_sel,
    output logic             ir_load,
    output logic             pc_load,
    output logic [1:0]       pc_src,
    output logic             reg_we,
    output logic [1:0]       wb_src,
    output logic [1:0]       alu_op,
    output logic             alu_src_imm,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_ADDI = 3'd1,
        OP_NAND = 3'd2,
        OP_LUI  = 3'd3,
        OP_SW   = 3'd4,
        OP_LW   = 3'd5,
        OP_BEQ  = 3'd6,
        OP_JALR = 3'd7
    } opcode_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             done;
    opcode_t          op;

    assign op = opcode_t'(ir_opcode);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        done        = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_sel     = 1'b0;
        ir_load     = 1'b0;
        pc_load     = 1'b0;
        pc_src      = 2'b00;
        reg_we      = 1'b0;
        wb_src      = 2'b00;
        alu_op      = 2'b00;
        alu_src_imm = 1'b0;

        // ALU controls held stable from DECODE through WB for the datapath.
        if (state_q == S_DECODE || state_q == S_EXEC ||
            state_q == S_MEM    || state_q == S_WB) begin
            case (op)
                OP_ADDI, OP_SW, OP_LW: alu_src_imm = 1'b1;
                OP_NAND:               alu_op      = 2'b01;
                OP_LUI: begin
                    alu_op      = 2'b10;
                    alu_src_imm = 1'b1;
                end
                OP_BEQ:                alu_op      = 2'b11;
                default: ;
            endcase
        end

        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_load = 1'b1;
                    pc_load = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                case (op)
                    OP_SW, OP_LW: state_d = S_MEM;
                    OP_BEQ: begin
                        pc_load = alu_zero;
                        pc_src  = 2'b01;
                        done    = 1'b1;
                    end
                    OP_JALR: begin
                        reg_we  = 1'b1;
                        wb_src  = 2'b10;
                        pc_load = 1'b1;
                        pc_src  = 2'b10;
                        done    = 1'b1;
                    end
                    default: state_d = S_WB;
                endcase
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_sel = 1'b1;
                mem_we  = (op == OP_SW);
                if (mem_ack) begin
                    if (op == OP_SW) done = 1'b1;
                    else             state_d = S_WB;
                end
            end
            S_WB: begin
                reg_we = 1'b1;
                wb_src = (op == OP_LW) ? 2'b01 : 2'b00;
                done   = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        // run is only honoured at the instruction boundary.
        if (done) state_d = run ? S_FETCH : S_IDLE;
    end

    assign retired_d = retired_q + CNT_W'(done);
    assign state     = state_q;
    assign retired   = retired_q;

endmodule

// File: tb/tb_risc16_mc_ctrl.sv
// tb_risc16_mc_ctrl -- directed self-checking bench for risc16_mc_ctrl.
// Inputs change 1 time unit after the rising edge; outputs are checked a
// further unit later, well before the next edge.
module tb_risc16_mc_ctrl;

    logic        clk = 1'b0;
    logic        rst, run, alu_zero, mem_ack;
    logic [2:0]  ir_opcode;
    logic        mem_req, mem_we, mem_sel, ir_load, pc_load, reg_we, alu_src_imm;
    logic [1:0]  pc_src, wb_src, alu_op;
    logic [2:0]  state;
    logic [15:0] retired;

    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;

    risc16_mc_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .run(run), .ir_opcode(ir_opcode),
        .alu_zero(alu_zero), .mem_ack(mem_ack), .mem_req(mem_req),
        .mem_we(mem_we), .mem_sel(mem_sel), .ir_load(ir_load),
        .pc_load(pc_load), .pc_src(pc_src), .reg_we(reg_we), .wb_src(wb_src),
        .alu_op(alu_op), .alu_src_imm(alu_src_imm), .state(state),
        .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [12:0] st(input logic req, input logic we, input logic sel,
                                       input logic irl, input logic pcl, input logic [1:0] pcs,
                                       input logic rwe, input logic [1:0] wbs,
                                       input logic [1:0] aop, input logic aimm);
        return {req, we, sel, irl, pcl, pcs, rwe, wbs, aop, aimm};
    endfunction

    function automatic logic [12:0] obs();
        return {mem_req, mem_we, mem_sel, ir_load, pc_load, pc_src,
                reg_we, wb_src, alu_op, alu_src_imm};
    endfunction

    // Check state and strobes for the current cycle, then advance one clock.
    task automatic cyc(input string tag, input logic [2:0] es, input logic [12:0] estb);
        #1;
        chk({tag, ".state"}, 32'(state), 32'(es));
        chk({tag, ".strb"}, 32'(obs()), 32'(estb));
        @(posedge clk);
        #1;
    endtask

    localparam logic [12:0] Z  = 13'b0;
    logic [12:0] f_ok, f_wait;

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        f_ok   = st(1, 0, 0, 1, 1, 2'b00, 0, 2'b00, 2'b00, 0);
        f_wait = st(1, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0);

        // 1: reset, then ADD with zero-wait memory
        rst = 1'b1; run = 1'b1; mem_ack = 1'b1; ir_opcode = 3'd0; alu_zero = 1'b0;
        #3;
        chk("rst.state", 32'(state), 0);
        chk("rst.retired", 32'(retired), 0);
        chk("rst.strb", 32'(obs()), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        cyc("add.idle", 3'd0, Z);
        cyc("add.fetch", 3'd1, f_ok);
        cyc("add.dec", 3'd2, Z);
        cyc("add.exec", 3'd3, Z);
        chk("add.ret_pre", 32'(retired), 0);
        cyc("add.wb", 3'd5, st(0, 0, 0, 0, 0, 2'b00, 1, 2'b00, 2'b00, 0));
        chk("add.ret", 32'(retired), 1);

        // 2: LW with three memory wait cycles (8 cycles total)
        ir_opcode = 3'd5;
        cyc("lw.fetch", 3'd1, f_ok);
        cyc("lw.dec", 3'd2, st(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1));
        mem_ack = 1'b0;
        cyc("lw.exec", 3'd3, st(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1));
        for (int i = 0; i < 3; i++)
            cyc("lw.memw", 3'd4, st(1, 0, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1));
        mem_ack = 1'b1;
        cyc("lw.mem", 3'd4, st(1, 0, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1));
        chk("lw.ret_pre", 32'(retired), 1);
        cyc("lw.wb", 3'd5, st(0, 0, 0, 0, 0, 2'b00, 1, 2'b01, 2'b00, 1));
        chk("lw.ret", 32'(retired), 2);

        // 3: BEQ taken, then not taken
        ir_opcode = 3'd6; alu_zero = 1'b1;
        cyc("beq1.fetch", 3'd1, f_ok);
        cyc("beq1.dec", 3'd2, st(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b11, 0));
        cyc("beq1.exec", 3'd3, st(0, 0, 0, 0, 1, 2'b01, 0, 2'b00, 2'b11, 0));
        chk("beq1.ret", 32'(retired), 3);
        alu_zero = 1'b0;
        cyc("beq0.fetch", 3'd1, f_ok);
        cyc("beq0.dec", 3'd2, st(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b11, 0));
        cyc("beq0.exec", 3'd3, st(0, 0, 0, 0, 0, 2'b01, 0, 2'b00, 2'b11, 0));
        chk("beq0.ret", 32'(retired), 4);

        // 4: JALR with one fetch wait cycle
        ir_opcode = 3'd7; mem_ack = 1'b0;
        cyc("jalr.fetchw", 3'd1, f_wait);
        mem_ack = 1'b1;
        cyc("jalr.fetch", 3'd1, f_ok);
        cyc("jalr.dec", 3'd2, Z);
        cyc("jalr.exec", 3'd3, st(0, 0, 0, 0, 1, 2'b10, 1, 2'b10, 2'b00, 0));
        chk("jalr.ret", 32'(retired), 5);

        // 5: SW with run dropped during DECODE
        ir_opcode = 3'd4;
        cyc("sw.fetch", 3'd1, f_ok);
        run = 1'b0;
        cyc("sw.dec", 3'd2, st(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1));
        mem_ack = 1'b0;
        cyc("sw.exec", 3'd3, st(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1));
        cyc("sw.memw", 3'd4, st(1, 1, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1));
        mem_ack = 1'b1;
        cyc("sw.mem", 3'd4, st(1, 1, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1));
        chk("sw.ret", 32'(retired), 6);
        cyc("sw.idle1", 3'd0, Z);
        cyc("sw.idle2", 3'd0, Z);
        chk("sw.ret_hold", 32'(retired), 6);
        run = 1'b1;
        cyc("sw.idle3", 3'd0, Z);

        // 6: reset asserted while in MEM
        ir_opcode = 3'd5;
        cyc("rstm.fetch", 3'd1, f_ok);
        cyc("rstm.dec", 3'd2, st(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1));
        mem_ack = 1'b0;
        cyc("rstm.exec", 3'd3, st(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1));
        #1;
        chk("rstm.req_pre", 32'(mem_req), 1);
        rst = 1'b1;
        #1;
        chk("rstm.req", 32'(mem_req), 0);
        chk("rstm.state", 32'(state), 0);
        chk("rstm.retired", 32'(retired), 0);
        @(posedge clk); #1;
        chk("rstm.strb_hold", 32'(obs()), 0);
        rst = 1'b0; mem_ack = 1'b1;
        cyc("rstm.idle", 3'd0, Z);
        cyc("rstm.fetch2", 3'd1, f_ok);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
